// File: rtl/kd_tree_pkg.sv
// Shared definitions for the kd-tree controller: width helpers, state encoding,
// point field offsets and the per-state strobe decode.
package kd_tree_pkg;

    // Bits needed for one point coordinate.
    function automatic int dim_size(input int data_range);
        return $clog2(data_range);
    endfunction

    // Bits needed for a full packed point {z,y,x}.
    function automatic int center_size(input int dim, input int data_range);
        return dim * $clog2(data_range);
    endfunction

    // Bits needed for the per-iteration point counter.
    function automatic int counter_size(input int max_n);
        return $clog2(max_n);
    endfunction

    // Bits needed to hold the tree depth.
    function automatic int depth_size(input int max_depth);
        return $clog2(max_depth);
    endfunction

    // LSB position of coordinate idx (0 = x, 1 = y, 2 = z) inside a packed point.
    function automatic int field_lsb(input int idx, input int data_range);
        return idx * $clog2(data_range);
    endfunction

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_INIT    = 4'd1,
        ST_START   = 4'd2,
        ST_SORT    = 4'd3,
        ST_FETCH   = 4'd4,
        ST_SEND    = 4'd5,
        ST_DESCEND = 4'd6,
        ST_INC     = 4'd7,
        ST_UPDATE  = 4'd8,
        ST_CHECK   = 4'd9,
        ST_DONE    = 4'd10
    } kd_state_e;

    // Everything the controller broadcasts, kept together so it can be
    // registered as a single word.
    typedef struct packed {
        logic en;
        logic busy;
        logic init;
        logic start_iter;
        logic sorting;
        logic parent_switch;
        logic child_switch;
        logic fetch;
        logic receive_point;
        logic next_level;
        logic inc;
        logic update;
        logic done;
    } kd_strobe_t;

    // Moore decode of the strobes for a given state. sort_even selects the
    // parent phase of the sort sequence; the two switches are exclusive.
    function automatic kd_strobe_t strobe_decode(input kd_state_e st, input logic sort_even);
        kd_strobe_t s;
        s = '0;
        if (st != ST_IDLE) begin
            s.en   = 1'b1;
            s.busy = 1'b1;
        end else begin
            s.en   = 1'b0;
            s.busy = 1'b0;
        end
        case (st)
            ST_INIT:    s.init = 1'b1;
            ST_START:   s.start_iter = 1'b1;
            ST_SORT: begin
                s.sorting       = 1'b1;
                s.parent_switch = sort_even;
                s.child_switch  = ~sort_even;
            end
            ST_FETCH:   s.fetch = 1'b1;
            ST_SEND:    s.receive_point = 1'b1;
            ST_DESCEND: s.next_level = 1'b1;
            ST_INC:     s.inc = 1'b1;
            ST_UPDATE:  s.update = 1'b1;
            ST_DONE:    s.done = 1'b1;
            default:    s.done = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/kd_point_fetch.sv
// Point intake: valid/ready handshake with the upstream source and the
// register that presents the accepted point to the root node.
module kd_point_fetch
    import kd_tree_pkg::*;
#(
    parameter int center_w = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    input  logic                pt_valid,
    input  logic [center_w-1:0] pt_data,
    output logic                pt_ready,
    output logic                fire,
    output logic [center_w-1:0] point_out
);

    logic [center_w-1:0] point_r;
    logic                fire_s;

    // fetch_en is a registered state decode, so ready is Moore.
    assign pt_ready  = fetch_en;
    assign fire_s    = pt_valid & fetch_en;
    assign fire      = fire_s;
    assign point_out = point_r;

    // Capture the point on the accepting edge and hold it until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            point_r <= {center_w{1'b0}};
        end else if (fire_s) begin
            point_r <= pt_data;
        end else begin
            point_r <= point_r;
        end
    end

endmodule

// File: rtl/kd_tree_ctrl.sv
// Sequencer driving a kd-tree of cluster_PE nodes through k-means iterations:
// sort, stream every point down the tree, update, and stop on stability or
// on the iteration limit.
module kd_tree_ctrl
    import kd_tree_pkg::*;
#(
    parameter int dim        = 3,
    parameter int data_range = 255,
    parameter int max_n      = 1000,
    parameter int max_depth  = 16,
    parameter int iter_size  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    go,
    input  logic [counter_size(max_n)-1:0]          n_points,
    input  logic [depth_size(max_depth)-1:0]        tree_depth,
    input  logic [iter_size-1:0]                    max_iter,
    input  logic                                    pt_valid,
    input  logic [center_size(dim, data_range)-1:0] pt_data,
    output logic                                    pt_ready,
    input  logic                                    stable,
    output logic                                    en,
    output logic                                    init,
    output logic                                    start_iter,
    output logic                                    receive_point,
    output logic                                    next_level,
    output logic                                    inc,
    output logic                                    update,
    output logic                                    sorting,
    output logic                                    parent_switch,
    output logic                                    child_switch,
    output logic [center_size(dim, data_range)-1:0] point_out,
    output logic                                    busy,
    output logic                                    done,
    output logic [iter_size-1:0]                    iter_count
);

    localparam int CENTER_W = center_size(dim, data_range);
    localparam int CNT_W    = counter_size(max_n);
    localparam int DEPTH_W  = depth_size(max_depth);
    // Cycle counter must reach 2*D-1 during the sort sequence.
    localparam int CYC_W    = DEPTH_W + 1;

    localparam logic [CYC_W-1:0]     CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [iter_size-1:0] ITER_ONE = {{(iter_size-1){1'b0}}, 1'b1};
    localparam logic [iter_size-1:0] ITER_MAX = {iter_size{1'b1}};

    kd_state_e            state_r, state_nx_s;
    logic [CYC_W-1:0]     cyc_r, cyc_nx_s;
    logic [CNT_W-1:0]     pt_cnt_r, pt_cnt_nx_s;
    logic [iter_size-1:0] iter_r, iter_nx_s;
    logic [CNT_W-1:0]     n_r;
    logic [DEPTH_W-1:0]   d_r;
    logic [iter_size-1:0] max_iter_r;
    logic                 latch_s;
    kd_strobe_t           strb_r;

    logic                 fire_s;
    logic [iter_size-1:0] eff_max_s;
    logic [CYC_W-1:0]     sort_last_s;
    logic [CYC_W-1:0]     desc_last_s;
    logic                 d_zero_s;
    logic                 n_zero_s;

    // A limit of zero still runs one iteration.
    assign eff_max_s   = (max_iter_r == {iter_size{1'b0}}) ? ITER_ONE : max_iter_r;
    assign sort_last_s = {d_r, 1'b0} - CYC_ONE;
    assign desc_last_s = {1'b0, d_r} - CYC_ONE;
    assign d_zero_s    = (d_r == {DEPTH_W{1'b0}});
    assign n_zero_s    = (n_r == {CNT_W{1'b0}});

    // Next-state and counter update rules of the iteration sequencer.
    always_comb begin
        state_nx_s  = state_r;
        cyc_nx_s    = cyc_r;
        pt_cnt_nx_s = pt_cnt_r;
        iter_nx_s   = iter_r;
        latch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    state_nx_s  = ST_INIT;
                    latch_s     = 1'b1;
                    iter_nx_s   = {iter_size{1'b0}};
                    pt_cnt_nx_s = {CNT_W{1'b0}};
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_INIT: begin
                state_nx_s = ST_START;
            end
            ST_START: begin
                pt_cnt_nx_s = {CNT_W{1'b0}};
                cyc_nx_s    = {CYC_W{1'b0}};
                if (!d_zero_s) begin
                    state_nx_s = ST_SORT;
                end else if (n_zero_s) begin
                    state_nx_s = ST_UPDATE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_SORT: begin
                if (cyc_r == sort_last_s) begin
                    cyc_nx_s   = {CYC_W{1'b0}};
                    state_nx_s = n_zero_s ? ST_UPDATE : ST_FETCH;
                end else begin
                    cyc_nx_s   = cyc_r + CYC_ONE;
                end
            end
            ST_FETCH: begin
                if (fire_s) begin
                    state_nx_s = ST_SEND;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_SEND: begin
                cyc_nx_s   = {CYC_W{1'b0}};
                state_nx_s = d_zero_s ? ST_INC : ST_DESCEND;
            end
            ST_DESCEND: begin
                if (cyc_r == desc_last_s) begin
                    cyc_nx_s   = {CYC_W{1'b0}};
                    state_nx_s = ST_INC;
                end else begin
                    cyc_nx_s   = cyc_r + CYC_ONE;
                end
            end
            ST_INC: begin
                pt_cnt_nx_s = pt_cnt_r + CNT_ONE;
                if ((pt_cnt_r + CNT_ONE) == n_r) begin
                    state_nx_s = ST_UPDATE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_UPDATE: begin
                if (iter_r != ITER_MAX) begin
                    iter_nx_s = iter_r + ITER_ONE;
                end else begin
                    iter_nx_s = iter_r;
                end
                state_nx_s = ST_CHECK;
            end
            ST_CHECK: begin
                if (stable || (iter_r >= eff_max_s)) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, latched run parameters and registered strobes; the
    // strobes are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cyc_r      <= {CYC_W{1'b0}};
            pt_cnt_r   <= {CNT_W{1'b0}};
            iter_r     <= {iter_size{1'b0}};
            n_r        <= {CNT_W{1'b0}};
            d_r        <= {DEPTH_W{1'b0}};
            max_iter_r <= {iter_size{1'b0}};
            strb_r     <= '0;
        end else begin
            state_r  <= state_nx_s;
            cyc_r    <= cyc_nx_s;
            pt_cnt_r <= pt_cnt_nx_s;
            iter_r   <= iter_nx_s;
            if (latch_s) begin
                n_r        <= n_points;
                d_r        <= tree_depth;
                max_iter_r <= max_iter;
            end
            strb_r <= strobe_decode(state_nx_s, ~cyc_nx_s[0]);
        end
    end

    kd_point_fetch #(
        .center_w (CENTER_W)
    ) u_fetch (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (strb_r.fetch),
        .pt_valid  (pt_valid),
        .pt_data   (pt_data),
        .pt_ready  (pt_ready),
        .fire      (fire_s),
        .point_out (point_out)
    );

    assign en            = strb_r.en;
    assign busy          = strb_r.busy;
    assign init          = strb_r.init;
    assign start_iter    = strb_r.start_iter;
    assign sorting       = strb_r.sorting;
    assign parent_switch = strb_r.parent_switch;
    assign child_switch  = strb_r.child_switch;
    assign receive_point = strb_r.receive_point;
    assign next_level    = strb_r.next_level;
    assign inc           = strb_r.inc;
    assign update        = strb_r.update;
    assign done          = strb_r.done;
    assign iter_count    = iter_r;

endmodule

// File: tb/tb_kd_tree_ctrl.sv
// Scoreboard bench for kd_tree_ctrl: a reference model expands each run into
// the expected list of non-waiting cycles; a monitor pops and compares.
module tb_kd_tree_ctrl;

    logic        clk = 1'b0;
    logic        rst, go, pt_valid, pt_ready, stable;
    logic [9:0]  n_points;
    logic [3:0]  tree_depth;
    logic [7:0]  max_iter;
    logic [23:0] pt_data, point_out;
    logic        en, init, start_iter, receive_point, next_level, inc, update;
    logic        sorting, parent_switch, child_switch, busy, done;
    logic [7:0]  iter_count;

    kd_tree_ctrl dut (
        .clk(clk), .rst(rst), .go(go), .n_points(n_points), .tree_depth(tree_depth),
        .max_iter(max_iter), .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
        .stable(stable), .en(en), .init(init), .start_iter(start_iter),
        .receive_point(receive_point), .next_level(next_level), .inc(inc), .update(update),
        .sorting(sorting), .parent_switch(parent_switch), .child_switch(child_switch),
        .point_out(point_out), .busy(busy), .done(done), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    localparam int B_EN = 12, B_BUSY = 11, B_INIT = 10, B_START = 9, B_SORT = 8, B_PAR = 7;
    localparam int B_CHI = 6, B_RDY = 5, B_RECV = 4, B_NEXT = 3, B_INC = 2, B_UPD = 1, B_DONE = 0;
    localparam logic [12:0] ACT = 13'h1800;

    wire [12:0] act_w = {en, busy, init, start_iter, sorting, parent_switch, child_switch,
                         pt_ready, receive_point, next_level, inc, update, done};

    typedef struct {
        logic [12:0] w;
        logic [7:0]  it;
        bit          chk_pt;
        logic [23:0] pt;
    } exp_t;

    exp_t        sb_q[$];
    logic [23:0] src_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int vmode = 0;
    bit stab_on = 1'b0;
    int stable_at = 0;
    int upd_seen = 0;
    bit mon_en = 1'b0;
    bit in_fetch = 1'b0;

    assign stable = stab_on && (upd_seen >= stable_at);

    function automatic logic [12:0] bitw(input int b);
        logic [12:0] r;
        r = 13'd0;
        r[b] = 1'b1;
        return r;
    endfunction

    function automatic void push(input logic [12:0] w, input int it, input bit cp, input logic [23:0] p);
        exp_t e;
        e.w = w; e.it = 8'(it); e.chk_pt = cp; e.pt = p;
        sb_q.push_back(e);
    endfunction

    // Reference: a run is iters x (start, 2D sort phases, n points, update, check).
    function automatic int model_run(input int n, input int d, input int mi, input bit fixed);
        int eff, iters, k;
        logic [23:0] pt;
        eff   = (mi == 0) ? 1 : mi;
        iters = (stab_on && stable_at < eff) ? stable_at : eff;
        k = 0;
        push(ACT | bitw(B_INIT), 0, 0, 24'd0);
        for (int i = 1; i <= iters; i++) begin
            push(ACT | bitw(B_START), i - 1, 0, 24'd0);
            for (int s = 0; s < 2 * d; s++)
                push(ACT | bitw(B_SORT) | bitw((s % 2 == 0) ? B_PAR : B_CHI), i - 1, 0, 24'd0);
            for (int p = 0; p < n; p++) begin
                if (fixed) pt = {8'(3 * k + 3), 8'(3 * k + 2), 8'(3 * k + 1)};
                else       pt = 24'($urandom);
                k++;
                src_q.push_back(pt);
                push(ACT | bitw(B_RDY), i - 1, 0, 24'd0);
                push(ACT | bitw(B_RECV), i - 1, 1, pt);
                for (int l = 0; l < d; l++) push(ACT | bitw(B_NEXT), i - 1, 0, 24'd0);
                push(ACT | bitw(B_INC), i - 1, 0, 24'd0);
            end
            push(ACT | bitw(B_UPD), i - 1, 0, 24'd0);
            push(ACT, i, 0, 24'd0);
        end
        push(ACT | bitw(B_DONE), iters, 0, 24'd0);
        return iters;
    endfunction

    // Upstream source: pops on handshake, then presents the next point.
    initial begin
        logic [23:0] tmp;
        pt_valid = 1'b0;
        pt_data  = 24'd0;
        forever begin
            @(posedge clk);
            if (pt_valid && pt_ready && src_q.size() > 0) tmp = src_q.pop_front();
            #1;
            pt_data  = (src_q.size() > 0) ? src_q[0] : 24'd0;
            pt_valid = (src_q.size() > 0) &&
                       (vmode == 1 || (vmode == 2 && $urandom_range(0, 2) == 0));
        end
    end

    // Count updates so that stable can be raised in a chosen CHECK cycle.
    always @(negedge clk) if (update) upd_seen <= upd_seen + 1;

    // Monitor: every active cycle except repeated FETCH waits consumes one entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && act_w != 13'd0) begin
                if (pt_ready && in_fetch) begin
                    n_cmp++;
                    if (act_w !== (ACT | bitw(B_RDY))) begin
                        n_bad++;
                        $display("FAIL fetch_wait: got %b want %b", act_w, ACT | bitw(B_RDY));
                    end
                end else if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_cycle: got %b want idle", act_w);
                end else begin
                    e = sb_q.pop_front();
                    n_cmp++;
                    if (act_w !== e.w || iter_count !== e.it || (e.chk_pt && point_out !== e.pt)) begin
                        n_bad++;
                        $display("FAIL event: got w=%b it=%0d pt=%h want w=%b it=%0d pt=%h",
                                 act_w, iter_count, point_out, e.w, e.it, e.pt);
                    end
                end
                in_fetch = pt_ready;
            end else begin
                in_fetch = 1'b0;
            end
        end
    end

    task automatic check(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic run(input int n, input int d, input int mi, input int vm,
                       input bit stab, input int sat, input bit fixed, input bit chk_cyc);
        int iters, cyc;
        bit got;
        @(negedge clk);
        vmode = vm; stab_on = stab; stable_at = sat; upd_seen = 0;
        src_q.delete(); sb_q.delete();
        iters = model_run(n, d, mi, fixed);
        n_points = 10'(n); tree_depth = 4'(d); max_iter = 8'(mi);
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        cyc = 0; got = 1'b0;
        while (cyc < 20000 && !got) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
        check("done_seen", int'(got), 1);
        if (chk_cyc) check("run_cycles", cyc, 1 + iters * (1 + 2 * d + n * (3 + d) + 2) + 1);
        @(negedge clk);
        check("queue_drained", sb_q.size(), 0);
        check("idle_after_done", int'(busy), 0);
        check("final_iter", int'(iter_count), iters);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; go = 1'b0; n_points = 10'd0; tree_depth = 4'd0; max_iter = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'(act_w), 0);
        check("reset_point", int'(point_out), 0);
        check("reset_iter", int'(iter_count), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        run(2, 2, 1, 1, 1'b0, 0, 1'b1, 1'b1);   // strobe order, 19 cycles, 0x030201
        run(3, 1, 5, 2, 1'b1, 1, 1'b0, 1'b0);   // backpressure + stable exit
        run(1, 1, 3, 1, 1'b0, 0, 1'b0, 1'b1);   // limit exit
        run(0, 0, 2, 1, 1'b0, 0, 1'b0, 1'b1);   // n=0, D=0
        run(1, 2, 0, 1, 1'b0, 0, 1'b0, 1'b1);   // max_iter=0 behaves as 1
        run(0, 3, 1, 2, 1'b0, 0, 1'b0, 1'b1);   // n=0 with sorting

        // Reset in the middle of DESCEND.
        @(negedge clk);
        mon_en = 1'b0;
        vmode = 1; stab_on = 1'b0; src_q.delete(); sb_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(24'(i + 24'h100));
        n_points = 10'd2; tree_depth = 4'd3; max_iter = 8'd2;
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        cyc = 0;
        while (cyc < 200 && !next_level) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_descend", int'(next_level), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset_outputs", int'(act_w), 0);
        check("midrun_reset_point", int'(point_out), 0);
        check("midrun_reset_iter", int'(iter_count), 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        run(2, 1, 2, 1, 1'b0, 0, 1'b0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int vm;
            vm = (r % 2 == 0) ? 1 : 2;
            run($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), vm,
                1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b0, (vm == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
